// File: rtl/aq_mmu_utlb_refill_ctrl.sv
// uTLB miss/refill sequencer for one bank of ENTRY_NUM entries. It detects a lookup miss,
// requests a refill from the jTLB and writes the returned mapping into a chosen victim entry.
//
// Ports:
//   utlb_entry_clk, cpurst_b       : clock, async active-low reset
//   utlb_req_vld/_vpn              : lookup request from LSU/IFU side
//   utlb_entry_hit/_vld            : per-entry hit and valid vectors
//   utlb_flush                     : any entry invalidation (satp, tlb clear, inv-va)
//   utlb_jtlb_req/_vpn             : refill request to jTLB, held until ack
//   jtlb_utlb_ack/_refill_vld/...  : jTLB handshake and refill response
//   utlb_entry_upd, utlb_upd_*     : one-hot entry write strobe and write data
//   utlb_miss_stall                : requester must hold/replay
//   utlb_fault                     : one-cycle page-fault pulse
module aq_mmu_utlb_refill_ctrl #(
    parameter int ENTRY_NUM = 4,
    parameter int VPN_WIDTH = 28,
    parameter int PPN_WIDTH = 28,
    parameter int FLG_WIDTH = 15,
    parameter int PGS_WIDTH = 3
) (
    input  logic                 utlb_entry_clk,
    input  logic                 cpurst_b,
    input  logic                 utlb_req_vld,
    input  logic [VPN_WIDTH-1:0] utlb_req_vpn,
    input  logic [ENTRY_NUM-1:0] utlb_entry_hit,
    input  logic [ENTRY_NUM-1:0] utlb_entry_vld,
    input  logic                 utlb_flush,
    output logic                 utlb_jtlb_req,
    output logic [VPN_WIDTH-1:0] utlb_jtlb_vpn,
    input  logic                 jtlb_utlb_ack,
    input  logic                 jtlb_utlb_refill_vld,
    input  logic                 jtlb_utlb_fault,
    input  logic [PPN_WIDTH-1:0] jtlb_utlb_ppn,
    input  logic [FLG_WIDTH-1:0] jtlb_utlb_flg,
    input  logic [PGS_WIDTH-1:0] jtlb_utlb_pgs,
    output logic [ENTRY_NUM-1:0] utlb_entry_upd,
    output logic [VPN_WIDTH-1:0] utlb_upd_vpn,
    output logic [PPN_WIDTH-1:0] utlb_upd_ppn,
    output logic [FLG_WIDTH-1:0] utlb_upd_flg,
    output logic [PGS_WIDTH-1:0] utlb_upd_pgs,
    output logic                 utlb_miss_stall,
    output logic                 utlb_fault
);

    localparam int RR_W = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        UPD
    } state_e;

    state_e                 state_q, state_d;
    logic [VPN_WIDTH-1:0]   vpn_q, vpn_d;
    logic [PPN_WIDTH-1:0]   ppn_q, ppn_d;
    logic [FLG_WIDTH-1:0]   flg_q, flg_d;
    logic [PGS_WIDTH-1:0]   pgs_q, pgs_d;
    logic [RR_W-1:0]        rr_q, rr_d;
    logic                   discard_q, discard_d;
    logic                   fault_q, fault_d;

    logic                   miss;
    logic                   rsp_vld;
    logic                   drop;
    logic                   all_vld;
    logic [RR_W-1:0]        victim_idx;
    logic [ENTRY_NUM-1:0]   victim_oh;
    logic [ENTRY_NUM-1:0]   upd;

    assign miss = utlb_req_vld && ~|utlb_entry_hit;

    // A response is only accepted once the request has been acked,
    // including an ack and response arriving together.
    assign rsp_vld = jtlb_utlb_refill_vld
                   && ((state_q == WAIT) || ((state_q == REQ) && jtlb_utlb_ack));

    // A flush in the response cycle itself also discards it.
    assign drop = discard_q || utlb_flush;

    // Lowest invalid entry wins; round-robin only when every entry is valid.
    always_comb begin
        victim_idx = rr_q;
        for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
            if (!utlb_entry_vld[i]) begin
                victim_idx = RR_W'(i);
            end
        end
    end

    assign all_vld   = &utlb_entry_vld;
    assign victim_oh = ENTRY_NUM'(1) << victim_idx;

    always_comb begin
        state_d   = state_q;
        vpn_d     = vpn_q;
        rr_d      = rr_q;
        discard_d = discard_q;
        fault_d   = 1'b0;
        upd       = '0;
        ppn_d     = rsp_vld ? jtlb_utlb_ppn : ppn_q;
        flg_d     = rsp_vld ? jtlb_utlb_flg : flg_q;
        pgs_d     = rsp_vld ? jtlb_utlb_pgs : pgs_q;

        unique case (state_q)
            IDLE: begin
                if (miss) begin
                    vpn_d   = utlb_req_vpn;
                    state_d = REQ;
                end
            end
            REQ, WAIT: begin
                if (utlb_flush) begin
                    discard_d = 1'b1;
                end
                if ((state_q == REQ) && jtlb_utlb_ack && !jtlb_utlb_refill_vld) begin
                    state_d = WAIT;
                end
                if (rsp_vld) begin
                    discard_d = 1'b0;
                    fault_d   = jtlb_utlb_fault && !drop;
                    state_d   = (jtlb_utlb_fault || drop) ? IDLE : UPD;
                end
            end
            UPD: begin
                state_d = IDLE;
                if (!utlb_flush) begin
                    upd = victim_oh;
                    if (all_vld) begin
                        rr_d = (rr_q == RR_W'(ENTRY_NUM - 1)) ? '0 : rr_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge utlb_entry_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q   <= IDLE;
            vpn_q     <= '0;
            ppn_q     <= '0;
            flg_q     <= '0;
            pgs_q     <= '0;
            rr_q      <= '0;
            discard_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            vpn_q     <= vpn_d;
            ppn_q     <= ppn_d;
            flg_q     <= flg_d;
            pgs_q     <= pgs_d;
            rr_q      <= rr_d;
            discard_q <= discard_d;
            fault_q   <= fault_d;
        end
    end

    assign utlb_jtlb_req   = (state_q == REQ);
    assign utlb_jtlb_vpn   = vpn_q;
    assign utlb_entry_upd  = upd;
    assign utlb_upd_vpn    = vpn_q;
    assign utlb_upd_ppn    = ppn_q;
    assign utlb_upd_flg    = flg_q;
    assign utlb_upd_pgs    = pgs_q;
    assign utlb_miss_stall = (state_q != IDLE) || miss;
    assign utlb_fault      = fault_q;

    a_upd_onehot: assert property (
        @(posedge utlb_entry_clk) disable iff (!cpurst_b)
        $onehot0(utlb_entry_upd));

    a_vpn_stable: assert property (
        @(posedge utlb_entry_clk) disable iff (!cpurst_b)
        (utlb_jtlb_req && !jtlb_utlb_ack) |=> $stable(utlb_jtlb_vpn));

    // A response with no acked request outstanding is a jTLB protocol error.
    a_refill_proto: assert property (
        @(posedge utlb_entry_clk) disable iff (!cpurst_b)
        !(jtlb_utlb_refill_vld
          && ((state_q == IDLE) || ((state_q == REQ) && !jtlb_utlb_ack))));

endmodule
